// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and helpers for the interrupt collector.
package irq_pkg;

    localparam int N_IRQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_GAP   = 2'd2
    } irq_state_e;

    function automatic logic [N_IRQ-1:0] ones_mask(input int n);
        logic [N_IRQ-1:0] m;
        m = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: highest set request bit wins.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [N_IRQ-1:0] req,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    always_comb begin
        id = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (req[i]) id = ID_W'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/irq_collector.sv
// Interrupt collector: synchronise request lines, capture rising edges as
// pending bits, and offer the highest-priority unmasked one over valid/ready.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | nothing offered; latch highest pending&mask if any
//   ST_OFFER | vec_valid=1, vec_id frozen until handshake
//   ST_GAP   | one dead cycle after an accept
module irq_collector
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] mask,
    output logic             vec_valid,
    output logic [ID_W-1:0]  vec_id,
    input  logic             vec_ready,
    output logic [N_IRQ-1:0] pending,
    output logic             overflow,
    input  logic             clr_ovf
);

    logic [N_IRQ-1:0] s1_q, s2_q, s3_q;
    logic [N_IRQ-1:0] s1_d, s2_d, s3_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic [ID_W-1:0]  vec_id_q, vec_id_d;
    irq_state_e       state_q, state_d;

    logic [N_IRQ-1:0] edge_det;
    logic [N_IRQ-1:0] clr_vec;
    logic [ID_W-1:0]  enc_id;
    logic             enc_any;
    logic             handshake;
    logic             load_id;

    irq_prio_enc u_prio_enc (
        .req (pending_q & mask),
        .id  (enc_id),
        .any (enc_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            vec_id_q   <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            vec_id_q   <= vec_id_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        s1_d     = irq_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        edge_det = s2_q & ~s3_q;

        clr_vec = '0;
        if (handshake) clr_vec[vec_id_q] = 1'b1;

        // A new edge on the bit being accepted re-arms it without counting as lost.
        pending_d  = ((pending_q & ~clr_vec) | edge_det) & ones_mask(N_IRQ);
        overflow_d = (|(edge_det & pending_q & ~clr_vec)) | (overflow_q & ~clr_ovf);

        vec_id_d = load_id ? enc_id : vec_id_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enc_any)   state_d = ST_OFFER;
            ST_OFFER: if (vec_ready) state_d = ST_GAP;
            ST_GAP:                  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vec_valid = (state_q == ST_OFFER);
        handshake = (state_q == ST_OFFER) && vec_ready;
        load_id   = (state_q == ST_IDLE) && enc_any;
    end

    assign vec_id   = vec_id_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_collector.sv
// Directed bench for irq_collector with a cycle-level behavioural model.
module tb_irq_collector;

    logic       clk;
    logic       rst;
    logic [7:0] irq_in;
    logic [7:0] mask;
    logic       vec_valid;
    logic [2:0] vec_id;
    logic       vec_ready;
    logic [7:0] pending;
    logic       overflow;
    logic       clr_ovf;

    int total = 0;
    int bad   = 0;

    irq_collector dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask      (mask),
        .vec_valid (vec_valid),
        .vec_id    (vec_id),
        .vec_ready (vec_ready),
        .pending   (pending),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: samples of irq_in at the last three edges; a line's edge takes
    // effect two edges after it is first sampled high.
    logic [7:0] h1, h2, h3;
    logic [7:0] m_pend, m_e, m_clr;
    logic       m_ovf, m_offer, m_gap, m_hs;
    logic [2:0] m_id;
    int         cyc;
    int         acc_q[$];
    int         acc_t[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h1 = '0; h2 = '0; h3 = '0;
            m_pend = '0; m_ovf = 1'b0; m_offer = 1'b0; m_gap = 1'b0; m_id = '0;
            cyc++;
        end else begin
            cyc++;
            m_e   = h2 & ~h3;
            m_hs  = m_offer && vec_ready;
            m_clr = m_hs ? (8'h01 << m_id) : 8'h00;
            m_ovf = ((m_e & m_pend & ~m_clr) != 0) || (m_ovf && !clr_ovf);
            if (m_offer) begin
                if (m_hs) begin
                    acc_q.push_back(int'(m_id));
                    acc_t.push_back(cyc);
                    m_offer = 1'b0;
                    m_gap   = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if ((m_pend & mask) != 0) begin
                for (int i = 7; i >= 0; i--) begin
                    if (m_pend[i] && mask[i]) begin
                        m_id = 3'(i);
                        break;
                    end
                end
                m_offer = 1'b1;
            end
            m_pend = (m_pend & ~m_clr) | m_e;
            h3 = h2; h2 = h1; h1 = irq_in;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_valid",    vec_valid, m_offer);
            check("cyc_id",       vec_id,    m_id);
            check("cyc_pending",  pending,   m_pend);
            check("cyc_overflow", overflow,  m_ovf);
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    int n0;

    initial begin
        rst = 1'b1; irq_in = '0; mask = 8'hFF; vec_ready = 1'b0; clr_ovf = 1'b0;
        wait_n(3);
        check("rst_valid",    vec_valid, 0);
        check("rst_id",       vec_id,    0);
        check("rst_pending",  pending,   0);
        check("rst_overflow", overflow,  0);
        rst = 1'b0;
        wait_n(3);

        // single request on bit 2
        vec_ready = 1'b1; irq_in = 8'h04;
        wait_n(3);
        check("single_early", vec_valid, 0);
        irq_in = 8'h00;
        wait_n(1);
        check("single_valid", vec_valid, 1);
        check("single_id",    vec_id,    2);
        wait_n(1);
        check("single_pend",  pending,   0);
        check("single_gap",   vec_valid, 0);
        check("single_log",   acc_q[acc_q.size()-1], 2);
        wait_n(4);

        // priority: bits 7 and 0 together
        n0 = acc_q.size();
        irq_in = 8'h81;
        wait_n(3);
        irq_in = 8'h00;
        wait_n(8);
        check("prio_count",  acc_q.size(), n0 + 2);
        check("prio_first",  acc_q[n0], 7);
        check("prio_second", acc_q[n0+1], 0);
        check("prio_spacing", acc_t[n0+1] - acc_t[n0], 3);

        // masking
        mask = 8'hDF; irq_in = 8'h20;
        wait_n(3);
        irq_in = 8'h00;
        wait_n(4);
        check("mask_pend",  pending,   8'h20);
        check("mask_valid", vec_valid, 0);
        mask = 8'hFF;
        wait_n(1);
        check("mask_valid_on", vec_valid, 1);
        check("mask_id",       vec_id,    5);
        wait_n(2);
        check("mask_log",  acc_q[acc_q.size()-1], 5);
        check("mask_pend0", pending, 0);
        wait_n(2);

        // backpressure, no preemption, no retraction on mask clear
        vec_ready = 1'b0; irq_in = 8'h02;
        wait_n(3);
        irq_in = 8'h00;
        wait_n(1);
        check("bp_valid0", vec_valid, 1);
        check("bp_id0",    vec_id,    1);
        irq_in = 8'h40; mask = 8'hFD;
        for (int i = 0; i < 10; i++) begin
            wait_n(1);
            if (i == 2) irq_in = 8'h00;
            check("bp_hold_valid", vec_valid, 1);
            check("bp_hold_id",    vec_id,    1);
        end
        check("bp_pend", pending, 8'h42);
        n0 = acc_q.size();
        mask = 8'hFF; vec_ready = 1'b1;
        wait_n(8);
        check("bp_first",  acc_q[n0], 1);
        check("bp_second", acc_q[n0+1], 6);

        // overflow set, clear, and set-wins-over-clear
        vec_ready = 1'b0; mask = 8'h00; irq_in = 8'h08;
        wait_n(3);
        irq_in = 8'h00;
        wait_n(3);
        irq_in = 8'h08;
        wait_n(3);
        irq_in = 8'h00;
        wait_n(2);
        check("ovf_set",  overflow, 1);
        check("ovf_pend", pending,  8'h08);
        clr_ovf = 1'b1;
        wait_n(1);
        clr_ovf = 1'b0;
        check("ovf_clr", overflow, 0);
        wait_n(2);
        irq_in = 8'h08;
        wait_n(2);
        clr_ovf = 1'b1;
        wait_n(1);
        clr_ovf = 1'b0; irq_in = 8'h00;
        check("ovf_set_wins", overflow, 1);

        // handshake clear coincident with a new edge on the same bit
        wait_n(2);
        clr_ovf = 1'b1;
        wait_n(1);
        clr_ovf = 1'b0;
        check("hs_ovf_clr", overflow, 0);
        mask = 8'hFF;
        wait_n(2);
        check("hs_valid", vec_valid, 1);
        check("hs_id",    vec_id,    3);
        irq_in = 8'h08;
        wait_n(2);
        vec_ready = 1'b1;
        wait_n(1);
        vec_ready = 1'b0; irq_in = 8'h00;
        check("hs_pend_kept", pending,  8'h08);
        check("hs_no_ovf",    overflow, 0);
        check("hs_gap",       vec_valid, 0);
        vec_ready = 1'b1;
        wait_n(5);
        check("hs_drained", pending, 0);
        check("hs_log",     acc_q[acc_q.size()-1], 3);

        // reset during OFFER
        vec_ready = 1'b0; irq_in = 8'h0C;
        wait_n(3);
        irq_in = 8'h00;
        wait_n(1);
        check("rmo_valid", vec_valid, 1);
        check("rmo_pend",  pending,   8'h0C);
        check("rmo_id",    vec_id,    3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rmo_valid_drop", vec_valid, 0);
        check("rmo_pend_drop",  pending,   0);
        check("rmo_ovf_drop",   overflow,  0);
        wait_n(2);
        rst = 1'b0;
        wait_n(6);
        check("rmo_quiet_valid", vec_valid, 0);
        check("rmo_quiet_pend",  pending,   0);

        // line already high at reset release counts as an edge, once
        @(negedge clk);
        #2 rst = 1'b1; irq_in = 8'h10; vec_ready = 1'b1;
        wait_n(2);
        rst = 1'b0;
        n0 = acc_q.size();
        wait_n(6);
        check("rel_count", acc_q.size(), n0 + 1);
        check("rel_id",    acc_q[n0], 4);
        wait_n(4);
        check("rel_once_pend",  pending,   0);
        check("rel_once_valid", vec_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
